io_uart_tx: RTL
===============

Name: io_uart_tx

Overview:
- Memory-mapped UART transmitter on the processor's I/O write/read bus (address window 0x00007ff0–0x00007fff).
- Consumes the processor's I/O write strobe, 4-bit I/O address and 32-bit write data.
- Buffers bytes in a small FIFO and serialises them 8N1 on TXD.
- Returns status combinationally on IOReadData, so single-cycle lw instructions complete in one clock.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per serial bit (10 MHz / 115200); must be ≥2.
- FIFO_DEPTH, 8, byte entries; power of two, 2..64.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- IOWriteEn  in  1  1 = valid I/O store this cycle.
- IOAddr  in  4  byte address within the I/O window.
- IOWriteData  in  32  store data.
- IOReadData  out  32  load data, combinational from IOAddr.
- TXD  out  1  serial line; idle high.
- TxBusy  out  1  1 = FSM not IDLE or FIFO not empty.

Behaviour:
Register map (IOAddr):
- 0x0 TXDATA: write pushes IOWriteData[7:0]; read returns 0.
- 0x4 STATUS (read): bit0 busy (= TxBusy), bit1 full, bit2 empty, bit3 overflow (sticky), bits[10:4] count (zero-extended), all other bits 0.
- 0x4 STATUS (write): IOWriteData[3]=1 clears overflow; other bits ignored.
- Other addresses: writes ignored, reads return 0.

Reset (RESET=0, async):
- FIFO empty, count 0, overflow 0, FSM IDLE, baud counter 0, TXD=1, TxBusy=0.
- Reset mid-frame aborts the frame immediately; TXD goes high asynchronously; queued bytes are discarded.

Push rules:
- Push on rising CLK when IOWriteEn && IOAddr==0x0 && !full.
- Full is evaluated before any same-cycle pop: a write while full is dropped and sets overflow, even if a pop occurs that cycle.
- If an overflow-clear and an overflow-set occur in the same cycle, set wins.

FSM (states IDLE, START, DATA, STOP):
- IDLE: if !empty, pop the head into shift register, load baud counter with CLKS_PER_BIT-1, TXD←0, go to START. Otherwise TXD=1.
- START / DATA / STOP: baud counter decrements each cycle. At 0 it reloads CLKS_PER_BIT-1 and the bit advances.
- START→DATA: TXD←shift[0], bit index ←0.
- DATA: shift right, LSB first. After bit index 7 completes, TXD←1, go to STOP.
- STOP→IDLE after one bit time.
- Latency: a byte pushed into an empty FIFO while IDLE at edge N gives TXD low from edge N+1.
- Frame length is exactly 10×CLKS_PER_BIT cycles, TXD falling edge to end of stop bit.
- Back-to-back bytes: IDLE lasts exactly one cycle between frames (stop bit then one idle-high cycle).

Outputs and widths:
- TXD is registered; no glitches.
- count is $clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro IO_UART_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP carrying even parity (XOR of the 8 data bits). Frame becomes 11×CLKS_PER_BIT cycles; STATUS bit11 reads 1 (parity present).
- Undefined: 8N1 as above; STATUS bit11 reads 0; no PARITY state exists.

Decomposition:
- Package io_uart_pkg holds:
  - register offsets ADDR_TXDATA=4'h0, ADDR_STATUS=4'h4;
  - STATUS bit indices;
  - FSM state enum (2 bits, plus PARITY under macro).
- One sub-module, io_uart_fifo: synchronous FIFO with push/pop/full/empty/count; async active-low reset; parameter DEPTH.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset, then hold idle 20 cycles → TXD=1, TxBusy=0, STATUS read = 0x00000004.
- Write 0x000000A5 to 0x0 → TXD low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles. Total 40 cycles, then TxBusy=0.
- 6 writes in consecutive cycles (0x11..0x16) → first pops immediately, next 4 queue. The last write is dropped because full is evaluated before pop. STATUS shows overflow=1, count=4. 0x11..0x15 appear on TXD in order, each 41 cycles apart (frame-start to frame-start); 0x16 is never sent.
- Write 0x8 to 0x4 → overflow clears. Same cycle as a dropped push → overflow remains 1.
- Drive RESET=0 at cycle 15 of a frame → TXD=1 asynchronously and STATUS=0x4 after release; no further frame starts.
- With IO_UART_PARITY_EN, send 0x07 → parity bit 1; frame 44 cycles; STATUS bit11=1.

Source files
------------

// File: rtl/io_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit layout and FSM states. Optional parity frame bit: IO_UART_PARITY_EN.
package io_uart_pkg;

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_COUNT_W   = 7;
  localparam int STAT_PARITY    = 11;

  // Bit of a STATUS write that clears the sticky overflow flag.
  localparam int OVF_CLEAR_BIT = 3;

`ifdef IO_UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } tx_state_e;

  localparam logic PARITY_PRESENT = 1'b1;
`else
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam logic PARITY_PRESENT = 1'b0;
`endif

endpackage

// File: rtl/io_uart_fifo.sv
// Synchronous byte FIFO with first-word fall-through head, occupancy count and
// async active-low reset. Pushes while full and pops while empty are ignored.
module io_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // the pointers and count, which lets this map onto plain RAM/register files.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS registers feed a byte FIFO that
// is serialised LSB first on TXD. Define IO_UART_PARITY_EN for an even-parity bit.
module io_uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IOWriteEn,
  input  logic [3:0]  IOAddr,
  input  logic [31:0] IOWriteData,
  output logic [31:0] IOReadData,
  output logic        TXD,
  output logic        TxBusy
);

  import io_uart_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

  // Bus decode
  logic wr_txdata;
  logic wr_status;
  logic ovf_set;
  logic ovf_clr;
  logic overflow;
  logic unused_wdata;

  // FIFO interface
  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  // Serialiser state
  tx_state_e     state, state_d;
  logic [BW-1:0] baud_cnt, baud_d;
  logic [7:0]    shift, shift_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic          txd_q, txd_d;
  logic          baud_done;
`ifdef IO_UART_PARITY_EN
  logic          parity_q, parity_d;
`endif

  assign wr_txdata    = IOWriteEn && (IOAddr == ADDR_TXDATA);
  assign wr_status    = IOWriteEn && (IOAddr == ADDR_STATUS);
  // Full is sampled before any same-edge pop, so a write while full is lost.
  assign fifo_push    = wr_txdata && !fifo_full;
  assign ovf_set      = wr_txdata && fifo_full;
  assign ovf_clr      = wr_status && IOWriteData[OVF_CLEAR_BIT];
  assign unused_wdata = ^IOWriteData[31:8];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  io_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (fifo_push),
    .push_data (IOWriteData[7:0]),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      baud_cnt <= '0;
      shift    <= '0;
      bit_idx  <= '0;
      txd_q    <= 1'b1;
`ifdef IO_UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      shift    <= shift_d;
      bit_idx  <= bit_idx_d;
      txd_q    <= txd_d;
`ifdef IO_UART_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign baud_done = (baud_cnt == '0);

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would otherwise infer a latch.
  always_comb begin
    state_d   = state;
    baud_d    = baud_cnt;
    shift_d   = shift;
    bit_idx_d = bit_idx;
    txd_d     = txd_q;
    fifo_pop  = 1'b0;
`ifdef IO_UART_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state)
      IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          baud_d   = BAUD_RELOAD;
          txd_d    = 1'b0;
          state_d  = START;
`ifdef IO_UART_PARITY_EN
          parity_d = ^fifo_head;
`endif
        end
      end

      START: begin
        if (baud_done) begin
          baud_d    = BAUD_RELOAD;
          txd_d     = shift[0];
          shift_d   = shift >> 1;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud_cnt - BW'(1);
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_d = BAUD_RELOAD;
          if (bit_idx == 3'd7) begin
`ifdef IO_UART_PARITY_EN
            txd_d   = parity_q;
            state_d = PARITY;
`else
            txd_d   = 1'b1;
            state_d = STOP;
`endif
          end else begin
            txd_d     = shift[0];
            shift_d   = shift >> 1;
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          baud_d = baud_cnt - BW'(1);
        end
      end

`ifdef IO_UART_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          baud_d  = BAUD_RELOAD;
          txd_d   = 1'b1;
          state_d = STOP;
        end else begin
          baud_d = baud_cnt - BW'(1);
        end
      end
`endif

      STOP: begin
        if (baud_done) begin
          baud_d  = BAUD_RELOAD;
          state_d = IDLE;
        end else begin
          baud_d = baud_cnt - BW'(1);
        end
      end

      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign TXD    = txd_q;
  assign TxBusy = (state != IDLE) || !fifo_empty;

  // Loads complete in the same cycle, so the read path is purely combinational.
  always_comb begin
    IOReadData = '0;
    if (IOAddr == ADDR_STATUS) begin
      IOReadData[STAT_BUSY]     = TxBusy;
      IOReadData[STAT_FULL]     = fifo_full;
      IOReadData[STAT_EMPTY]    = fifo_empty;
      IOReadData[STAT_OVERFLOW] = overflow;
      IOReadData[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
      IOReadData[STAT_PARITY]   = PARITY_PRESENT;
    end
  end

endmodule
